// File: rtl/oneshot_multi_if.sv
// oneshot_multi_if: control and pulse bundle for oneshot_multi.
// master drives triggers and config; slave returns pulses and arm state.
interface oneshot_multi_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 9
);
  logic                ce;
  logic [CHANNELS-1:0] trigger;
  logic [CHANNELS-1:0] retrig;
  logic [CHANNELS-1:0] rearm;
  logic [WIDTH-1:0]    duration;
  logic [CHANNELS-1:0] q;
  logic [CHANNELS-1:0] armed;
  logic                any_q;

  modport master (
    output ce, trigger, retrig, rearm, duration,
    input  q, armed, any_q
  );

  modport slave (
    input  ce, trigger, retrig, rearm, duration,
    output q, armed, any_q
  );
endinterface

// File: rtl/oneshot_multi.sv
// oneshot_multi: multi-channel ce-gated one-shot pulse generator.
// Define ONESHOT_MULTI_SYNC_EN to add a 2-stage trigger synchroniser.
module oneshot_multi #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 9
) (
  input  logic           clk,
  input  logic           reset_n,
  oneshot_multi_if.slave bus
);

  typedef logic [WIDTH-1:0] cnt_t;
  localparam cnt_t ONE  = cnt_t'(1);
  localparam cnt_t ZERO = '0;

  logic [CHANNELS-1:0] trig_in;

`ifdef ONESHOT_MULTI_SYNC_EN
  logic [CHANNELS-1:0] sync1_q;
  logic [CHANNELS-1:0] sync2_q;

  // Reset high so a trigger held through reset never looks like an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else if (bus.ce) begin
      sync1_q <= bus.trigger;
      sync2_q <= sync1_q;
    end
  end

  assign trig_in = sync2_q;
`else
  assign trig_in = bus.trigger;
`endif

  logic [CHANNELS-1:0]            s_q, s_d;
  logic [CHANNELS-1:0]            q_q, q_d;
  logic [CHANNELS-1:0]            armed_q, armed_d;
  logic [CHANNELS-1:0][WIDTH-1:0] c_q, c_d;
  logic                           any_q_q, any_q_d;
  logic [CHANNELS-1:0]            edg;
  logic [CHANNELS-1:0]            fire;
  cnt_t                           eff_dur;

  assign eff_dur = (bus.duration == ZERO) ? ONE : bus.duration;

  always_comb begin
    s_d     = s_q;
    q_d     = q_q;
    armed_d = armed_q;
    c_d     = c_q;
    edg     = '0;
    fire    = '0;
    if (bus.ce) begin
      edg = trig_in & ~s_q;
      s_d = trig_in;
      for (int i = 0; i < CHANNELS; i++) begin
        fire[i] = edg[i] & armed_q[i]
                & (bus.retrig[i] | ~q_q[i]);
        if (fire[i]) begin
          q_d[i] = 1'b1;
          c_d[i] = eff_dur - ONE;
          if (!bus.retrig[i])
            armed_d[i] = 1'b0;
        end else if (q_q[i]) begin
          if (c_q[i] == ZERO)
            q_d[i] = 1'b0;
          else
            c_d[i] = c_q[i] - ONE;
        end
        // A same-tick rearm loses to a successful fire.
        if (bus.rearm[i] && !fire[i])
          armed_d[i] = 1'b1;
      end
    end
    any_q_d = |q_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_q     <= '1;
      q_q     <= '0;
      armed_q <= '1;
      c_q     <= '0;
      any_q_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      q_q     <= q_d;
      armed_q <= armed_d;
      c_q     <= c_d;
      any_q_q <= any_q_d;
    end
  end

  assign bus.q     = q_q;
  assign bus.armed = armed_q;
  assign bus.any_q = any_q_q;

endmodule

// File: tb/tb_oneshot_multi.sv
// tb_oneshot_multi: directed vectors for oneshot_multi.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_oneshot_multi;

  localparam int CH = 4;
  localparam int W  = 9;
`ifdef ONESHOT_MULTI_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  oneshot_multi_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

  oneshot_multi #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Two idle clocks then one ce clock; ce left high afterwards.
  task automatic cetick();
    bus.ce = 1'b0;
    tick(2);
    bus.ce = 1'b1;
    tick(1);
  endtask

  initial begin
    bus.ce       = 1'b1;
    bus.trigger  = '0;
    bus.retrig   = '1;
    bus.rearm    = '0;
    bus.duration = 9'd5;
    tick(2);
    chk("rst_q", bus.q, 0);
    chk("rst_any", bus.any_q, 0);
    chk("rst_armed", bus.armed, 4'hF);
    reset_n = 1'b1;
    tick(3);

    // basic 5-tick pulse on ch0
    bus.trigger[0] = 1'b1;
    tick(LAT);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t1_q", bus.q, 4'b0001);
      chk("t1_any", bus.any_q, 1);
    end
    tick();
    chk("t1_q_end", bus.q, 0);
    chk("t1_any_end", bus.any_q, 0);

    // ce every 3rd clock, ch1, 4 ticks
    bus.duration = 9'd4;
    bus.trigger[1] = 1'b1;
    repeat (LAT) cetick();
    for (int k = 0; k < 4; k++) begin
      cetick();
      chk("t2_q", bus.q, 4'b0010);
    end
    cetick();
    chk("t2_q_end", bus.q, 0);
    bus.trigger[1] = 1'b0;
    repeat (LAT + 2) cetick();
    bus.ce = 1'b0;
    bus.trigger[1] = 1'b1;
    tick();
    bus.trigger[1] = 1'b0;
    tick();
    bus.ce = 1'b1;
    tick();
    chk("t2_glitch", bus.q[1], 0);
    for (int k = 0; k < LAT + 2; k++) begin
      cetick();
      chk("t2_glitch", bus.q[1], 0);
    end

    // retrigger ch2 on its 4th high tick
    bus.duration = 9'd6;
    for (int t = 0; t < 12 + LAT; t++) begin
      bus.trigger[2] = (t == 1 || t == 2) ? 1'b0 : 1'b1;
      tick();
      if (t >= LAT)
        chk("t3_q2", bus.q[2], (t - LAT) <= 8 ? 1 : 0);
    end

    // non-retriggerable ch3
    bus.retrig[3] = 1'b0;
    bus.duration = 9'd3;
    chk("t4_armed0", bus.armed[3], 1);
    bus.trigger[3] = 1'b1;
    tick(LAT + 1);
    chk("t4_q_a", bus.q[3], 1);
    chk("t4_disarm", bus.armed[3], 0);
    tick();
    chk("t4_q_b", bus.q[3], 1);
    tick();
    chk("t4_q_c", bus.q[3], 1);
    tick();
    chk("t4_q_end", bus.q[3], 0);
    bus.trigger[3] = 1'b0;
    tick(LAT + 2);
    bus.trigger[3] = 1'b1;
    tick(LAT + 1);
    chk("t4_nofire", bus.q[3], 0);
    bus.trigger[3] = 1'b0;
    tick(LAT + 2);
    bus.rearm[3] = 1'b1;
    tick();
    bus.rearm[3] = 1'b0;
    chk("t4_rearmed", bus.armed[3], 1);
    bus.trigger[3] = 1'b1;
    tick(LAT + 1);
    chk("t4_refire", bus.q[3], 1);
    chk("t4_redisarm", bus.armed[3], 0);
    tick(3);
    chk("t4_refire_end", bus.q[3], 0);
    bus.trigger[3] = 1'b0;
    tick(LAT + 2);
    bus.trigger[3] = 1'b1;
    tick(LAT);
    bus.rearm[3] = 1'b1;
    tick();
    bus.rearm[3] = 1'b0;
    chk("t4_same_q", bus.q[3], 0);
    chk("t4_same_arm", bus.armed[3], 1);
    tick();
    chk("t4_same_q2", bus.q[3], 0);

    // trigger held high through reset release
    bus.trigger = '1;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick(LAT + 4);
    chk("t5_held_q", bus.q, 0);
    chk("t5_held_any", bus.any_q, 0);

    // zero duration gives a 1-tick pulse
    bus.trigger[0] = 1'b0;
    tick(LAT + 2);
    bus.duration = 9'd0;
    bus.trigger[0] = 1'b1;
    tick(LAT + 1);
    chk("t5_dur0_q", bus.q, 4'b0001);
    tick();
    chk("t5_dur0_end", bus.q, 0);

    // asynchronous reset mid-pulse
    bus.duration = 9'd10;
    bus.trigger[1] = 1'b0;
    bus.trigger[3] = 1'b0;
    tick(LAT + 2);
    bus.trigger[1] = 1'b1;
    bus.trigger[3] = 1'b1;
    tick(LAT + 1);
    chk("t6_q", bus.q, 4'b1010);
    chk("t6_armed", bus.armed, 4'b0111);
    tick(2);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_q", bus.q, 0);
    chk("t6_rst_any", bus.any_q, 0);
    chk("t6_rst_armed", bus.armed, 4'hF);
    tick();
    reset_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
